// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitude shift-add / restoring divide,
// one result bit per cycle, with sign fix-up folded into the final iteration.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_funct;
  logic             r_neg_a;
  logic             r_neg_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_out;

  logic             w_sa;
  logic             w_sb;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_div0;
  logic             w_ovf;
  logic [WIDTH-1:0] w_special;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_hi_nxt;
  logic [WIDTH-1:0]   w_lo_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_result;

  // Handshake: an op is taken on a rising edge with in_ready && in_valid; a
  // result is released on a rising edge with out_valid && out_ready.
  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign Out         = r_out;
  assign o_dbg_state = r_state;

  // Operand decode at acceptance; unsigned ops never flag a negative operand.
  always_comb begin
    w_sa      = ~funct[0] | (funct == 3'b001);
    w_sb      = (funct == 3'b000) | (funct == 3'b001) | (funct == 3'b100) | (funct == 3'b110);
    w_neg_a   = w_sa & A[WIDTH-1];
    w_neg_b   = w_sb & B[WIDTH-1];
    w_mag_a   = w_neg_a ? -A : A;
    w_mag_b   = w_neg_b ? -B : B;
    w_div0    = funct[2] & (B == '0);
    w_ovf     = funct[2] & ~funct[0] & (A == {1'b1, {(WIDTH-1){1'b0}}}) & (B == '1);
    w_special = '1;
    if (w_div0)     w_special = funct[1] ? A : '1;
    else if (w_ovf) w_special = funct[1] ? '0 : A;
  end

  // One iteration: {r_hi, r_lo} is the product accumulator or {remainder, quotient}.
  always_comb begin
    w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    w_trial  = {r_hi, r_lo[WIDTH-1]};
    w_diff   = w_trial - {1'b0, r_opb};
    w_ge     = ~w_diff[WIDTH];
    w_hi_nxt = w_sum[WIDTH:1];
    w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
    if (r_funct[2]) begin
      w_hi_nxt = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
    end
    w_prod = {w_hi_nxt, w_lo_nxt};
    if (r_neg_a ^ r_neg_b) w_prod = -w_prod;
    w_quo  = (r_neg_a ^ r_neg_b) ? -w_lo_nxt : w_lo_nxt;
    w_rem  = r_neg_a ? -w_hi_nxt : w_hi_nxt;
    case (r_funct)
      3'b000:          w_result = w_prod[WIDTH-1:0];
      3'b100, 3'b101:  w_result = w_quo;
      3'b110, 3'b111:  w_result = w_rem;
      default:         w_result = w_prod[2*WIDTH-1:WIDTH];
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_funct <= '0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_opb   <= '0;
      r_out   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_funct <= funct;
          r_neg_a <= w_neg_a;
          r_neg_b <= w_neg_b;
          r_hi    <= '0;
          r_lo    <= w_mag_a;
          r_opb   <= w_mag_b;
          r_cnt   <= CW'(WIDTH);
          if (w_div0 | w_ovf) begin
            r_out   <= w_special;
            r_state <= S_DONE;
          end else begin
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_out   <= w_result;
            r_state <= S_DONE;
          end
        end
        S_DONE: if (out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, arithmetic, special cases,
// backpressure and mid-operation reset, with an expected-result queue.
`timescale 1ns/1ps
module tb_muldiv_unit;
  localparam int W = 32;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   funct;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Out;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_mis = 0;
  logic [W-1:0] exp_q[$];

  always #5 Clock = ~Clock;

  muldiv_unit #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Out(Out), .o_dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Drive one request, push its expectation, then scramble inputs after acceptance.
  task automatic start_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp);
    @(negedge Clock);
    funct = f; A = a; B = b; in_valid = 1'b1;
    exp_q.push_back(exp);
    @(posedge Clock); #1;
    in_valid = 1'b0;
    funct = 3'($urandom_range(0, 7));
    A = $urandom;
    B = $urandom;
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int lat = 0;
    logic [W-1:0] exp;
    while (!out_valid && lat < 200) begin
      check({tag, "_busy_in_ready"}, W'(in_ready), '0);
      @(posedge Clock); #1;
      lat++;
    end
    check({tag, "_latency"}, W'(lat), W'(exp_lat));
    check({tag, "_queue_nonempty"}, W'(exp_q.size() > 0), W'(1));
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check({tag, "_out"}, Out, exp);
    end
  endtask

  task automatic ack(input string tag);
    @(negedge Clock);
    out_ready = 1'b1;
    @(posedge Clock); #1;
    out_ready = 1'b0;
    check({tag, "_ack_in_ready"}, W'(in_ready), W'(1));
    check({tag, "_ack_out_valid"}, W'(out_valid), '0);
  endtask

  task automatic run(input string tag, input logic [2:0] f, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
    start_op(f, a, b, exp);
    wait_result(tag, lat);
    ack(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    funct = '0; A = '0; B = '0;
    repeat (2) @(posedge Clock);
    #1;
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_out", Out, '0);
    @(negedge Clock);
    Reset = 1'b0;

    run("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 32);
    run("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32);
    run("mulhu",  3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32);
    run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
    run("mul_m1", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32);

    run("div",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
    run("rem",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
    run("divu", 3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32);
    run("remu", 3'b111, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32);

    run("div0",    3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 0);
    run("rem0",    3'b110, 32'd5,         32'd0,         32'd5,         0);
    run("divu0",   3'b101, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 0);
    run("remu0",   3'b111, 32'h1234_5678, 32'd0,         32'h1234_5678, 0);
    run("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0);

    // Backpressure: result must hold while in_valid pulses in DONE.
    start_op(3'b000, 32'h1234, 32'h10, 32'h0001_2340);
    wait_result("bp", 32);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      in_valid = i[0];
      funct = 3'($urandom_range(0, 7));
      A = $urandom;
      B = $urandom;
      @(posedge Clock); #1;
      check("bp_out_valid", W'(out_valid), W'(1));
      check("bp_out", Out, 32'h0001_2340);
      check("bp_in_ready", W'(in_ready), '0);
    end
    @(negedge Clock);
    in_valid = 1'b0;
    ack("bp");
    run("bp_mul", 3'b000, 32'd3, 32'd4, 32'd12, 32);

    // Reset lands on the 10th iteration edge of a DIV.
    start_op(3'b100, 32'd1000, 32'd3, 32'd333);
    repeat (9) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    check("mid_rst_out_valid", W'(out_valid), '0);
    check("mid_rst_in_ready", W'(in_ready), W'(1));
    check("mid_rst_out", Out, '0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());

    run("divu_after_rst", 3'b101, 32'd100, 32'd7, 32'd14, 32);
    run("remu_after_rst", 3'b111, 32'd100, 32'd7, 32'd2, 32);

    check("queue_drained", W'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit with a parametrised operand width and a valid/ready handshake on both sides. It sits in the execute stage beside the combinational ALU and handles every funct3 of OPC_ARI_RTYPE with funct7 = 0000001. The pipeline stalls on `in_ready`/`out_valid` while an operation is in flight. It computes one result bit per cycle, giving a fixed, predictable latency.

## Interface

- `WIDTH`, default 32: operand and result width; legal values are ≥ 4.
- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  unit can accept an operation.
- `funct`  in  3  RV32M funct3:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU;
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `A`  in  WIDTH  rs1 operand.
- `B`  in  WIDTH  rs2 operand.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `Out`  out  WIDTH  result.

## Operation

- **States:** IDLE, BUSY, DONE.
- **`in_ready`** is high only in IDLE.
- **`out_valid`** is high only in DONE.
- **Acceptance** occurs on an edge where the state is IDLE and `in_valid` is high. At that edge `funct`, `A` and `B` are latched, and later input changes have no effect.
- **Signed handling:**
  - Signed operands are converted to magnitudes first.
  - MUL/MULH/DIV/REM treat A and B as signed. MULHSU treats A as signed and B as unsigned. MULHU/DIVU/REMU treat both as unsigned.
  - The unsigned core runs shift-add (multiply) or restoring shift-subtract (divide), 1 bit per cycle, for WIDTH cycles.
- **Sign fix-up:**
  - The product is negated as a 2·WIDTH two's-complement value when exactly one signed-interpreted operand is negative.
  - The quotient is negated when the dividend and divisor signs differ.
  - The remainder takes the sign of the dividend.
- **Result selection:**
  - MUL returns the product bits [WIDTH-1:0].
  - MULH/MULHSU/MULHU return the product bits [2·WIDTH-1:WIDTH].
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- **Special cases** are detected at acceptance. They bypass BUSY and go straight to DONE with the result loaded:
  - Divisor 0: DIV/DIVU return all ones; REM/REMU return A.
  - Signed overflow (DIV/REM, A = most-negative value, B = all ones): DIV returns A; REM returns 0.
- **Result hold:** in DONE, `Out` and `out_valid` hold steady until `out_ready` is high. On the edge with `out_ready` high the state goes DONE→IDLE. `Out` keeps the last result until the next completion.
- **Iteration counter:** `$clog2(WIDTH)+1` bits. It wraps only by reload at acceptance and never free-runs.
- **`Reset`** takes priority over everything, in any state, including mid-BUSY:
  - State goes to IDLE.
  - `out_valid` = 0, `in_ready` = 1, `Out` = 0.
  - Internal accumulators and the counter are cleared, and the in-flight operation is discarded.

## Timing

- **Reset values:** `in_ready` = 1, `out_valid` = 0, `Out` = 0, state = IDLE.
- **Normal operations:** acceptance at edge E0; iterations occur at edges E1…E_WIDTH. Sign fix-up is folded into edge E_WIDTH. The state becomes DONE after E_WIDTH, so `out_valid` rises exactly WIDTH edges after acceptance.
- **Special cases:** `out_valid` is high immediately after E0.
- **Return to IDLE:** the DONE→IDLE edge with `out_ready` sets `in_ready` in the following cycle. A new operation cannot be accepted on the same edge as the result handshake.
- **Throughput:** one normal operation per WIDTH+2 cycles when the consumer is always ready.
- **Unqualified inputs:** `in_valid` is ignored outside IDLE. `out_ready` is ignored outside DONE.
- **Combinational paths:** none from inputs to outputs. All outputs are registered or decoded directly from state.

## Test plan

1. **MUL latency:** WIDTH=32, MUL with A=7, B=0xFFFFFFFD → `Out`=0xFFFFFFEB. `out_valid` must rise exactly 32 edges after acceptance, and `in_ready` must be low throughout BUSY.
2. **High-half multiplies:**
   - MULH with A=B=0x80000000 → 0x40000000.
   - MULHU with the same operands → 0x40000000.
   - MULHSU with A=B=0xFFFFFFFF → 0xFFFFFFFF.
   - MUL with the same operands → 0x00000001.
3. **Divide and remainder:** A=0xFFFFFFF9, B=2:
   - DIV → 0xFFFFFFFD; REM → 0xFFFFFFFF.
   - DIVU → 0x7FFFFFFC; REMU → 0x00000001.
   - Each must have a 32-edge latency.
4. **Special cases:**
   - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIVU x/0 → 0xFFFFFFFF.
   - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
   - All must show `out_valid` the cycle after acceptance.
5. **Backpressure:** hold `out_ready` low for 10 cycles in DONE. `Out` and `out_valid` must stay stable, and `in_ready` must stay 0 while `in_valid` pulses. Then raise `out_ready`: `in_ready` must be 1 the next cycle, and a new MUL 3×4 → 12.
6. **Reset mid-operation:** assert `Reset` for one cycle at iteration 10 of a DIV. The next cycle must show `out_valid`=0, `in_ready`=1, `Out`=0. A following DIVU 100/7 → 14, and REMU 100/7 → 2.
